// File: rtl/rpsc_latch_test_sequencer.sv
// Surveillance test of the RPSC card-10 latch channels: inject a trip, confirm set, clear, confirm release.
// Outputs register one cycle after each state decision; no handshake, abort/field trip preempt the sequence.
module rpsc_latch_test_sequencer #(
    parameter int N_CH        = 8,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 64,
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [N_CH-1:0] ch_mask,
    input  logic [N_CH-1:0] trip_in,
    input  logic [N_CH-1:0] la_in,
    output logic [N_CH-1:0] test_inj,
    output logic [N_CH-1:0] latch_clr,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_CH-1:0] fail_map,
    output logic [N_CH-1:0] skip_map,
    output logic [CW-1:0]   cur_ch
);
    localparam int MAX_CYC = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int TW      = $clog2(MAX_CYC) + 1;
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] LAST_CH     = CW'(N_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_SET, S_HOLD, S_CLR, S_WAIT_CLR, S_NEXT, S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   timer;
    logic [CW-1:0]   cur_ch_nxt;
    logic [N_CH-1:0] fail_nxt, skip_nxt, ch_bit;
    logic            start_acc, abort_hit;
    logic            ch_en, ch_trip, ch_la;

    assign ch_en   = ch_mask[cur_ch];
    assign ch_trip = trip_in[cur_ch];
    assign ch_la   = la_in[cur_ch];

    always_comb begin
        state_nxt  = state;
        cur_ch_nxt = cur_ch;
        fail_nxt   = fail_map;
        skip_nxt   = skip_map;
        start_acc  = 1'b0;
        abort_hit  = 1'b0;
        ch_bit     = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    state_nxt  = S_SELECT;
                    cur_ch_nxt = '0;
                    fail_nxt   = '0;
                    skip_nxt   = '0;
                end
            end
            S_SELECT: begin
                if (!ch_en || ch_trip) begin
                    skip_nxt[cur_ch] = 1'b1;
                    state_nxt        = S_NEXT;
                end else begin
                    state_nxt = S_SET;
                end
            end
            // A real field trip always wins over the test step in progress.
            S_SET: begin
                if (ch_trip) begin
                    skip_nxt[cur_ch] = 1'b1;
                    state_nxt        = S_NEXT;
                end else if (ch_la) begin
                    state_nxt = S_HOLD;
                end else if (timer == TO_LAST) begin
                    fail_nxt[cur_ch] = 1'b1;
                    state_nxt        = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ch_trip) begin
                    skip_nxt[cur_ch] = 1'b1;
                    state_nxt        = S_NEXT;
                end else if (timer == SETTLE_LAST) begin
                    state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                if (ch_trip) begin
                    skip_nxt[cur_ch] = 1'b1;
                    state_nxt        = S_NEXT;
                end else begin
                    state_nxt = S_WAIT_CLR;
                end
            end
            S_WAIT_CLR: begin
                if (ch_trip) begin
                    skip_nxt[cur_ch] = 1'b1;
                    state_nxt        = S_NEXT;
                end else if (!ch_la) begin
                    state_nxt = S_NEXT;
                end else if (timer == TO_LAST) begin
                    fail_nxt[cur_ch] = 1'b1;
                    state_nxt        = S_NEXT;
                end
            end
            S_NEXT: begin
                if (cur_ch == LAST_CH) begin
                    state_nxt = S_DONE;
                end else begin
                    cur_ch_nxt = cur_ch + CW'(1);
                    state_nxt  = S_SELECT;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Abort discards this cycle's map updates so fail_map keeps what was accumulated.
        if (abort && state != S_IDLE && state != S_DONE) begin
            abort_hit  = 1'b1;
            state_nxt  = S_DONE;
            cur_ch_nxt = cur_ch;
            fail_nxt   = fail_map;
            skip_nxt   = skip_map;
        end

        ch_bit[cur_ch_nxt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            cur_ch    <= '0;
            fail_map  <= '0;
            skip_map  <= '0;
            test_inj  <= '0;
            latch_clr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= (state_nxt != state) ? '0 : timer + TW'(1);
            cur_ch    <= cur_ch_nxt;
            fail_map  <= fail_nxt;
            skip_map  <= skip_nxt;
            test_inj  <= (state_nxt == S_SET) ? ch_bit : '0;
            latch_clr <= (state_nxt == S_CLR) ? ch_bit : '0;
            busy      <= (state_nxt != S_IDLE);
            done      <= (state_nxt == S_DONE);
            if (start_acc) begin
                pass <= 1'b0;
            end else if (state_nxt == S_DONE) begin
                pass <= !abort_hit && (fail_nxt == '0);
            end
        end
    end
endmodule

// File: tb/tb_rpsc_latch_test_sequencer.sv
// Bench: a card model answers injections and clears; expectations come from per-channel outcome rules.
module tb_rpsc_latch_test_sequencer;
    localparam int N = 8;
    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         reset, start, abort;
    logic [N-1:0] ch_mask, trip_in, la_in;
    logic [N-1:0] test_inj, latch_clr, fail_map, skip_map;
    logic         busy, done, pass;
    logic [2:0]   cur_ch;

    int n_chk = 0;
    int n_err = 0;

    rpsc_latch_test_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .ch_mask(ch_mask), .trip_in(trip_in), .la_in(la_in),
        .test_inj(test_inj), .latch_clr(latch_clr), .busy(busy), .done(done),
        .pass(pass), .fail_map(fail_map), .skip_map(skip_map), .cur_ch(cur_ch)
    );

    always #5 clk = ~clk;

    // Card behaviour per channel: latch sets after set_dly injected cycles, releases clr_dly cycles after a clear (0 = never).
    int set_dly[N];
    int clr_dly[N];
    int gen = 1;
    int card_gen = 0;
    int mon_gen = 0;
    int inj_run[N];
    int clr_pend[N];

    always @(negedge clk) begin
        if (card_gen != gen) begin
            card_gen = gen;
            la_in = '0;
            for (int i = 0; i < N; i++) begin
                inj_run[i] = 0;
                clr_pend[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (test_inj[i] === 1'b1) begin
                    inj_run[i]++;
                    if (set_dly[i] != 0 && inj_run[i] == set_dly[i]) la_in[i] = 1'b1;
                end else begin
                    inj_run[i] = 0;
                end
                if (latch_clr[i] === 1'b1) begin
                    clr_pend[i] = clr_dly[i];
                end else if (clr_pend[i] > 0) begin
                    clr_pend[i]--;
                    if (clr_pend[i] == 0) la_in[i] = 1'b0;
                end
            end
        end
    end

    int inj_cnt[N];
    int clr_cnt[N];
    int done_cnt, viol;
    logic         d_pass;
    logic [N-1:0] d_fail, d_skip;

    always @(negedge clk) begin
        if (mon_gen != gen) begin
            mon_gen = gen;
            done_cnt = 0;
            viol = 0;
            for (int i = 0; i < N; i++) begin
                inj_cnt[i] = 0;
                clr_cnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (test_inj[i] === 1'b1) inj_cnt[i]++;
                if (latch_clr[i] === 1'b1) clr_cnt[i]++;
            end
            if ($countones(test_inj | latch_clr) > 1 || (|test_inj && |latch_clr)) viol++;
            if (done === 1'b1) begin
                done_cnt++;
                d_pass = pass;
                d_fail = fail_map;
                d_skip = skip_map;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic card_init();
        gen++;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done_cnt == 0 && k < 3000) begin
            step();
            k++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt > 0), 1);
    endtask

    task automatic wait_inj(input int ch, input logic lvl);
        int k;
        k = 0;
        while (test_inj[ch] !== lvl && k < 3000) begin
            step();
            k++;
        end
        chk($sformatf("wait_inj%0d_%0d", ch, lvl), 32'(test_inj[ch]), 32'(lvl));
    endtask

    task automatic wait_clr(input int ch);
        int k;
        k = 0;
        while (latch_clr[ch] !== 1'b1 && k < 3000) begin
            step();
            k++;
        end
        chk($sformatf("wait_clr%0d", ch), 32'(latch_clr[ch]), 1);
    endtask

    // Expected outcome of one full sequence, channel by channel.
    logic [N-1:0] exp_fail, exp_skip;
    int exp_inj[N];
    int exp_clr[N];

    task automatic predict();
        exp_fail = '0;
        exp_skip = '0;
        for (int i = 0; i < N; i++) begin
            if (!ch_mask[i] || trip_in[i]) begin
                exp_skip[i] = 1'b1;
                exp_inj[i] = 0;
                exp_clr[i] = 0;
            end else begin
                exp_clr[i] = 1;
                if (set_dly[i] >= 1 && set_dly[i] <= TO) begin
                    exp_inj[i] = set_dly[i];
                    if (clr_dly[i] == 0 || clr_dly[i] > TO) exp_fail[i] = 1'b1;
                end else begin
                    exp_inj[i] = TO;
                    exp_fail[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_run(input string tag);
        chk({tag, "_done_cnt"}, 32'(done_cnt), 1);
        chk({tag, "_fail_map"}, 32'(d_fail), 32'(exp_fail));
        chk({tag, "_skip_map"}, 32'(d_skip), 32'(exp_skip));
        chk({tag, "_pass"}, 32'(d_pass), 32'(exp_fail == '0));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_inj%0d", tag, i), 32'(inj_cnt[i]), 32'(exp_inj[i]));
            chk($sformatf("%s_clr%0d", tag, i), 32'(clr_cnt[i]), 32'(exp_clr[i]));
        end
        chk({tag, "_onehot"}, 32'(viol), 0);
        step();
        chk({tag, "_busy_after"}, 32'(busy), 0);
        chk({tag, "_done_after"}, 32'(done), 0);
    endtask

    task automatic set_card(input int sd, input int cd);
        for (int i = 0; i < N; i++) begin
            set_dly[i] = sd;
            clr_dly[i] = cd;
        end
    endtask

    task automatic full_run(input string tag);
        card_init();
        predict();
        pulse_start();
        chk({tag, "_busy_start"}, 32'(busy), 1);
        chk({tag, "_cur_ch_start"}, 32'(cur_ch), 0);
        wait_done(tag);
        check_run(tag);
    endtask

    initial begin
        int r;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        ch_mask = '0;
        trip_in = '0;
        set_card(3, 2);
        repeat (3) step();
        chk("rst_test_inj", 32'(test_inj), 0);
        chk("rst_latch_clr", 32'(latch_clr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_fail_map", 32'(fail_map), 0);
        chk("rst_skip_map", 32'(skip_map), 0);
        chk("rst_cur_ch", 32'(cur_ch), 0);
        reset = 1'b0;
        step();

        // Abort while idle must do nothing.
        card_init();
        abort = 1'b1;
        repeat (5) step();
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 0);
        chk("idle_abort_done", 32'(done_cnt), 0);

        ch_mask = 8'hFF;
        set_card(3, 2);
        full_run("all_good");

        set_card(3, 2);
        set_dly[2] = 0;
        full_run("ch2_never");

        ch_mask = 8'hF0;
        set_card(3, 2);
        full_run("mask_f0");

        // Field trip on channel 5 a few cycles into its HOLD.
        ch_mask = 8'hFF;
        set_card(3, 2);
        card_init();
        predict();
        exp_skip[5] = 1'b1;
        exp_clr[5] = 0;
        pulse_start();
        wait_inj(5, 1'b1);
        wait_inj(5, 1'b0);
        repeat (3) step();
        trip_in[5] = 1'b1;
        wait_done("trip5");
        check_run("trip5");
        trip_in = '0;

        // Abort in WAIT_CLR of channel 3 (its latch never releases).
        set_card(3, 2);
        clr_dly[3] = 0;
        card_init();
        pulse_start();
        wait_clr(3);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_done", 32'(done), 1);
        chk("abort_pass", 32'(pass), 0);
        chk("abort_test_inj", 32'(test_inj), 0);
        chk("abort_latch_clr", 32'(latch_clr), 0);
        chk("abort_fail_map", 32'(fail_map), 0);
        chk("abort_skip_map", 32'(skip_map), 0);
        chk("abort_cur_ch", 32'(cur_ch), 3);
        step();
        chk("abort_busy_after", 32'(busy), 0);
        chk("abort_done_after", 32'(done), 0);
        chk("abort_ch4_inj", 32'(inj_cnt[4]), 0);

        // Start pulsed mid-SET is ignored; reset then clears everything with no clear pulse.
        set_card(3, 2);
        set_dly[1] = 0;
        card_init();
        pulse_start();
        wait_inj(1, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("midstart_busy", 32'(busy), 1);
        chk("midstart_cur_ch", 32'(cur_ch), 1);
        chk("midstart_test_inj", 32'(test_inj), 32'h02);
        reset = 1'b1;
        step();
        chk("midrst_test_inj", 32'(test_inj), 0);
        chk("midrst_latch_clr", 32'(latch_clr), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_cur_ch", 32'(cur_ch), 0);
        chk("midrst_fail_skip", 32'({fail_map, skip_map}), 0);
        gen++;
        reset = 1'b0;
        repeat (80) step();
        r = 0;
        for (int i = 0; i < N; i++) r += clr_cnt[i] + inj_cnt[i];
        chk("midrst_no_activity", 32'(r), 0);
        chk("midrst_idle_busy", 32'(busy), 0);

        // Randomized card behaviour, masks and standing field trips.
        for (int run = 0; run < 6; run++) begin
            ch_mask = 8'($urandom_range(0, 255));
            for (int i = 0; i < N; i++) begin
                trip_in[i] = ($urandom_range(0, 7) == 0);
                r = $urandom_range(0, 12);
                set_dly[i] = (r == 11) ? 64 : (r == 12) ? 65 : r;
                r = $urandom_range(0, 9);
                clr_dly[i] = (r == 8) ? 64 : (r == 9) ? 65 : r;
            end
            full_run($sformatf("rand%0d", run));
            trip_in = '0;
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
